// File: rtl/spi_slave.sv
// SPI slave endpoint clocked entirely by clk: SCLK/SSbar/MOSI are oversampled,
// words shift MSB-first in any CPOL/CPHA mode through a one-entry tx buffer.
module spi_slave #(
  parameter int WORD_LENGTH = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SCLK,
  input  logic                   SSbar,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic                   MISO_oe,
  input  logic [WORD_LENGTH-1:0] WDATA,
  input  logic                   tx_data_valid,
  output logic                   tx_ready,
  output logic [WORD_LENGTH-1:0] RDATA,
  output logic                   rx_data_valid,
  output logic                   tx_underrun
);
  localparam int CW = $clog2(WORD_LENGTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q;
  logic [2:0]             sclkSync_q;
  logic [1:0]             ssSync_q;
  logic [1:0]             mosiSync_q;
  logic                   armed_q;
  logic [WORD_LENGTH-1:0] txShift_q;
  logic [WORD_LENGTH-1:0] rxShift_q;
  logic [WORD_LENGTH-1:0] txBuf_q;
  logic                   txFull_q;
  logic [CW-1:0]          bitCnt_q;
  logic                   reloadPend_q;
  logic                   holdFirst_q;
  logic                   underrunPend_q;
  logic                   wordDone_q;
  logic                   rxValid_q;
  logic                   miso_q;
  logic                   misoOe_q;
  logic [WORD_LENGTH-1:0] rdata_q;
  logic                   underrun_q;

  logic                   sclkEdge, leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic                   ssLow, lastBit, loadReq;
  logic [WORD_LENGTH-1:0] rxWord_d;

  assign sclkEdge   = sclkSync_q[1] ^ sclkSync_q[2];
  assign leadEdge   = sclkEdge && (sclkSync_q[1] != CPOL);
  assign trailEdge  = sclkEdge && (sclkSync_q[1] == CPOL);
  assign sampleEdge = CPHA ? trailEdge : leadEdge;
  assign shiftEdge  = CPHA ? leadEdge : trailEdge;
  assign ssLow      = ~ssSync_q[1];
  assign lastBit    = (bitCnt_q == CW'(WORD_LENGTH - 1));
  assign rxWord_d   = {rxShift_q[WORD_LENGTH-2:0], mosiSync_q[1]};

  // CPHA=0 reloads on the shift edge after a word, CPHA=1 right at its last sample.
  always_comb begin
    loadReq = 1'b0;
    if (state_q == IDLE) begin
      loadReq = armed_q && ssLow;
    end else if (ssLow) begin
      loadReq = CPHA ? (sampleEdge && lastBit) : (shiftEdge && reloadPend_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sclkSync_q     <= {3{CPOL}};
      ssSync_q       <= 2'b00;
      mosiSync_q     <= 2'b00;
      armed_q        <= 1'b0;
      txShift_q      <= '0;
      rxShift_q      <= '0;
      txBuf_q        <= '0;
      txFull_q       <= 1'b0;
      bitCnt_q       <= '0;
      reloadPend_q   <= 1'b0;
      holdFirst_q    <= 1'b0;
      underrunPend_q <= 1'b0;
      wordDone_q     <= 1'b0;
      rxValid_q      <= 1'b0;
      miso_q         <= 1'b0;
      misoOe_q       <= 1'b0;
      rdata_q        <= '0;
      underrun_q     <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[1:0], SCLK};
      ssSync_q   <= {ssSync_q[0], SSbar};
      mosiSync_q <= {mosiSync_q[0], MOSI};
      armed_q    <= armed_q | ssSync_q[1];
      wordDone_q <= 1'b0;
      rxValid_q  <= wordDone_q;
      miso_q     <= (state_q == ACTIVE) & txShift_q[WORD_LENGTH-1];
      misoOe_q   <= (state_q == ACTIVE);

      if (tx_data_valid && !txFull_q) begin
        txBuf_q  <= WDATA;
        txFull_q <= 1'b1;
      end

      // An empty-buffer load only counts as underrun once the word actually starts,
      // so the speculative reload after a frame's final word stays harmless.
      if (loadReq) begin
        txShift_q      <= txFull_q ? txBuf_q : '0;
        underrunPend_q <= !txFull_q;
        holdFirst_q    <= CPHA;
        if (txFull_q) txFull_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          bitCnt_q     <= '0;
          reloadPend_q <= 1'b0;
          if (armed_q && ssLow) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (!ssLow) begin
            state_q        <= IDLE;
            bitCnt_q       <= '0;
            reloadPend_q   <= 1'b0;
            holdFirst_q    <= 1'b0;
            underrunPend_q <= 1'b0;
          end else begin
            if (sampleEdge) begin
              rxShift_q <= rxWord_d;
              if (underrunPend_q && bitCnt_q == '0) begin
                underrun_q     <= 1'b1;
                underrunPend_q <= 1'b0;
              end
              if (lastBit) begin
                rdata_q    <= rxWord_d;
                wordDone_q <= 1'b1;
                bitCnt_q   <= '0;
                if (!CPHA) reloadPend_q <= 1'b1;
              end else begin
                bitCnt_q <= bitCnt_q + CW'(1);
              end
            end
            if (shiftEdge) begin
              if (!CPHA && reloadPend_q) begin
                reloadPend_q <= 1'b0;
              end else if (holdFirst_q) begin
                holdFirst_q <= 1'b0;
              end else begin
                txShift_q <= {txShift_q[WORD_LENGTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO          = miso_q;
  assign MISO_oe       = misoOe_q;
  assign tx_ready      = !txFull_q;
  assign RDATA         = rdata_q;
  assign rx_data_valid = rxValid_q;
  assign tx_underrun   = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench: one slave per SPI mode, driven by a bit-level master model and
// checked against word-level expectations for received, transmitted and flag values.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int HALF = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          sclk, ssbar, mosi, miso, misoOe, txValid, txReady, rxValid, underrun;
  logic [3:0][W-1:0]   wdata, rdata;

  int                  compared = 0;
  int                  mismatched = 0;
  int                  rxTotal [4];
  logic [W-1:0]        rxLog [4][64];
  logic [W-1:0]        txWords [8];
  logic [W-1:0]        mosiWords [8];
  logic [W-1:0]        masterRx [8];
  logic [W-1:0]        expRdata [4];
  bit                  expUnderrun [4];
  bit                  tryOverwrite = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gSlave
    spi_slave #(.WORD_LENGTH(W), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk[g]), .SSbar(ssbar[g]), .MOSI(mosi[g]),
      .MISO(miso[g]), .MISO_oe(misoOe[g]), .WDATA(wdata[g]), .tx_data_valid(txValid[g]),
      .tx_ready(txReady[g]), .RDATA(rdata[g]), .rx_data_valid(rxValid[g]),
      .tx_underrun(underrun[g])
    );
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rxValid[g] === 1'b1) begin
        rxLog[g][rxTotal[g] % 64] = rdata[g];
        rxTotal[g]++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeTx(input int m, input logic [W-1:0] d);
    wdata[m]   = d;
    txValid[m] = 1'b1;
    waitClk(1);
    txValid[m] = 1'b0;
  endtask

  // Master side of one frame; abortBits >= 0 raises SSbar after that many bits.
  task automatic applyStimulus(input int m, input int nWords, input int abortBits, input bit present);
    logic cpol, cpha;
    int   bitsDone;
    bit   stop;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    if (present) begin
      writeTx(m, txWords[0]);
      checkOutput($sformatf("m%0d preloadReady", m), 32'(txReady[m]), 0);
      if (tryOverwrite) writeTx(m, ~txWords[0]);
    end
    ssbar[m] = 1'b0;
    mosi[m]  = mosiWords[0][W-1];
    fork
      begin
        waitClk(8);
        bitsDone = 0;
        stop = 1'b0;
        for (int w = 0; w < nWords && !stop; w++) begin
          masterRx[w] = '0;
          for (int b = W - 1; b >= 0; b--) begin
            if (bitsDone == abortBits) begin
              stop = 1'b1;
              break;
            end
            if (cpha) begin
              sclk[m] = ~cpol;
              mosi[m] = mosiWords[w][b];
              waitClk(HALF);
              masterRx[w][b] = miso[m];
              sclk[m] = cpol;
              waitClk(HALF);
            end else begin
              masterRx[w][b] = miso[m];
              sclk[m] = ~cpol;
              waitClk(HALF);
              sclk[m] = cpol;
              if (b > 0) mosi[m] = mosiWords[w][b-1];
              else if (w + 1 < nWords) mosi[m] = mosiWords[w+1][W-1];
              waitClk(HALF);
            end
            bitsDone++;
          end
        end
      end
      begin
        if (present) begin
          for (int w = 1; w < nWords; w++) begin
            int t = 0;
            while (txReady[m] !== 1'b1 && t < 300) begin
              waitClk(1);
              t++;
            end
            checkOutput($sformatf("m%0d feedReady%0d", m, w), 32'(txReady[m]), 1);
            writeTx(m, txWords[w]);
          end
        end
      end
    join
    ssbar[m] = 1'b1;
    if (abortBits >= 0) begin
      waitClk(4);
      checkOutput($sformatf("m%0d abortOe", m), 32'(misoOe[m]), 0);
      waitClk(6);
    end else begin
      waitClk(10);
    end
    mosi[m] = 1'b0;
  endtask

  task automatic runAndCheck(input int m, input int nWords, input int abortBits, input bit present);
    int base;
    base = rxTotal[m];
    applyStimulus(m, nWords, abortBits, present);
    if (abortBits >= 0) begin
      if (!present && abortBits > 0) expUnderrun[m] = 1'b1;
      checkOutput($sformatf("m%0d abortPulses", m), 32'(rxTotal[m] - base), 0);
    end else begin
      if (!present) expUnderrun[m] = 1'b1;
      expRdata[m] = mosiWords[nWords-1];
      checkOutput($sformatf("m%0d pulses", m), 32'(rxTotal[m] - base), 32'(nWords));
      for (int w = 0; w < nWords; w++) begin
        checkOutput($sformatf("m%0d rxWord%0d", m, w), 32'(rxLog[m][(base + w) % 64]), 32'(mosiWords[w]));
        checkOutput($sformatf("m%0d misoWord%0d", m, w), 32'(masterRx[w]),
                    present ? 32'(txWords[w]) : 32'(0));
      end
    end
    checkOutput($sformatf("m%0d rdata", m), 32'(rdata[m]), 32'(expRdata[m]));
    checkOutput($sformatf("m%0d underrun", m), 32'(underrun[m]), 32'(expUnderrun[m]));
    checkOutput($sformatf("m%0d txReadyIdle", m), 32'(txReady[m]), 1);
    checkOutput($sformatf("m%0d oeIdle", m), 32'(misoOe[m]), 0);
    checkOutput($sformatf("m%0d misoIdle", m), 32'(miso[m]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m, n, base;
    bit present;
    rst_n = 1'b0;
    sclk = 4'b1100;
    ssbar = 4'b1111;
    mosi = '0;
    txValid = '0;
    wdata = '0;
    for (int g = 0; g < 4; g++) begin
      expRdata[g] = '0;
      expUnderrun[g] = 1'b0;
    end
    waitClk(3);
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("m%0d rstOe", g), 32'(misoOe[g]), 0);
      checkOutput($sformatf("m%0d rstReady", g), 32'(txReady[g]), 1);
      checkOutput($sformatf("m%0d rstRdata", g), 32'(rdata[g]), 0);
      checkOutput($sformatf("m%0d rstUnderrun", g), 32'(underrun[g]), 0);
    end
    rst_n = 1'b1;
    waitClk(6);

    tryOverwrite = 1'b1;
    txWords[0] = 8'hA5; mosiWords[0] = 8'h3C;
    runAndCheck(0, 1, -1, 1'b1);
    tryOverwrite = 1'b0;

    for (int k = 1; k < 4; k++) begin
      txWords[0] = 8'hC3; mosiWords[0] = 8'h81;
      runAndCheck(k, 1, -1, 1'b1);
    end

    for (int k = 0; k < 4; k += 3) begin
      txWords[0] = 8'h11; txWords[1] = 8'h22;
      mosiWords[0] = 8'h96; mosiWords[1] = 8'h4B;
      runAndCheck(k, 2, -1, 1'b1);
    end

    mosiWords[0] = 8'hE7;
    runAndCheck(0, 1, -1, 1'b0);
    txWords[0] = 8'h5E; mosiWords[0] = 8'h29;
    runAndCheck(0, 1, -1, 1'b1);

    txWords[0] = 8'h5A; mosiWords[0] = 8'hF0;
    runAndCheck(1, 1, 5, 1'b1);
    txWords[0] = 8'h3D; mosiWords[0] = 8'hB4;
    runAndCheck(1, 1, -1, 1'b1);

    base = rxTotal[2];
    repeat (16) begin
      sclk[2] = ~sclk[2];
      waitClk(HALF);
    end
    checkOutput("m2 deselSclkPulses", 32'(rxTotal[2] - base), 0);
    checkOutput("m2 deselSclkOe", 32'(misoOe[2]), 0);

    for (int i = 0; i < 12; i++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      present = ($urandom_range(0, 4) != 0);
      for (int w = 0; w < n; w++) begin
        txWords[w] = W'($urandom);
        mosiWords[w] = W'($urandom);
      end
      runAndCheck(m, n, -1, present);
    end

    mosiWords[0] = 8'hC6;
    txWords[0] = 8'h77;
    runAndCheck(0, 1, -1, 1'b1);
    writeTx(0, 8'h77);
    ssbar[0] = 1'b0;
    waitClk(8);
    repeat (3) begin
      sclk[0] = 1'b1; waitClk(HALF);
      sclk[0] = 1'b0; waitClk(HALF);
    end
    rst_n = 1'b0;
    waitClk(1);
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      expRdata[g] = '0;
      expUnderrun[g] = 1'b0;
    end
    checkOutput("rstMid miso", 32'(miso[0]), 0);
    checkOutput("rstMid oe", 32'(misoOe[0]), 0);
    checkOutput("rstMid txReady", 32'(txReady[0]), 1);
    checkOutput("rstMid rdata", 32'(rdata[0]), 0);
    checkOutput("rstMid rxValid", 32'(rxValid[0]), 0);
    checkOutput("rstMid underrun", 32'(underrun[0]), 0);
    base = rxTotal[0];
    repeat (4) begin
      sclk[0] = 1'b1; waitClk(HALF);
      sclk[0] = 1'b0; waitClk(HALF);
    end
    checkOutput("rstMid heldOe", 32'(misoOe[0]), 0);
    checkOutput("rstMid heldPulses", 32'(rxTotal[0] - base), 0);
    ssbar[0] = 1'b1;
    waitClk(10);
    txWords[0] = 8'h9C; mosiWords[0] = 8'h1F;
    runAndCheck(0, 1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
